// File: rtl/img_stream_pkg.sv
// Shared definitions for the image-stream path: state encoding, default
// geometry and a counter-width helper used by both FIFO writer and reader.
package img_stream_pkg;

  // Default geometry, shared with the FIFO writer side.
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_H_ACTIVE   = 640;
  localparam int unsigned DEFAULT_V_ACTIVE   = 480;
  localparam int unsigned DEFAULT_LINE_GAP   = 4;

  // Line reader state encoding.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output register for a valid/ready stream with frame/line flags.
// A load captures a new beat; without a load an accepted beat drains;
// a stalled beat holds data and flags stable.
module stream_out_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_sof,
  input  logic             load_eol,
  input  logic             load_eof,
  input  logic             ready,
  output logic             free,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             sof,
  output logic             eol,
  output logic             eof
);

  // Register can take a new beat when empty or when its beat leaves this cycle.
  assign free = !valid || ready;

  // Load / drain / hold of the output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      sof   <= 1'b0;
      eol   <= 1'b0;
      eof   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      sof   <= load_sof;
      eol   <= load_eol;
      eof   <= load_eof;
    end else if (ready) begin
      // Data and flags are left as-is; only valid qualifies them.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_line_reader.sv
// Drain side of the image-path FIFO: pops first-word-fall-through pixels and
// presents them as a framed valid/ready stream with an idle gap between lines.
module fifo_line_reader
  import img_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned H_ACTIVE   = DEFAULT_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEFAULT_V_ACTIVE,
  parameter int unsigned LINE_GAP   = DEFAULT_LINE_GAP
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  frame_start,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy
);

  localparam int unsigned XW = cnt_width(H_ACTIVE);
  localparam int unsigned YW = cnt_width(V_ACTIVE);
  localparam int unsigned GW = cnt_width(LINE_GAP + 1);

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  // Unused when LINE_GAP is 0 since GAP is never entered.
  localparam logic [GW-1:0] GAP_LAST = (LINE_GAP > 0) ? GW'(LINE_GAP - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [GW-1:0] gap_q, gap_d;

  logic out_free;
  logic load;
  logic at_x_last;
  logic at_y_last;

  assign at_x_last = (x_q == X_LAST);
  assign at_y_last = (y_q == Y_LAST);

  // Reset is folded into load so the FIFO never sees a pop while in reset.
  assign load       = (state_q == STREAM) && !fifo_empty && out_free && !sys_rst;
  assign fifo_rd_en = load;
  assign busy       = (state_q != IDLE) || m_valid;

  // Next-state and counter logic; counters move on pops, not on cycles.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        // Pulses arriving while the previous frame still drains are dropped.
        if (frame_start && !busy) begin
          state_d = STREAM;
          x_d     = '0;
          y_d     = '0;
        end
      end
      STREAM: begin
        if (load) begin
          if (at_x_last) begin
            x_d = '0;
            if (at_y_last) begin
              y_d     = '0;
              state_d = IDLE;
            end else begin
              y_d = y_q + 1'b1;
              if (LINE_GAP > 0) begin
                state_d = GAP;
                gap_d   = '0;
              end
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = STREAM;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
        gap_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
    end
  end

  stream_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .load      (load),
    .load_data (fifo_rd_data),
    .load_sof  ((x_q == '0) && (y_q == '0)),
    .load_eol  (at_x_last),
    .load_eof  (at_x_last && at_y_last),
    .ready     (m_ready),
    .free      (out_free),
    .valid     (m_valid),
    .data      (m_data),
    .sof       (m_sof),
    .eol       (m_eol),
    .eof       (m_eof)
  );

endmodule

// File: tb/tb_fifo_line_reader.sv
// Self-checking bench for fifo_line_reader: behavioural FWFT FIFO, scoreboard
// of expected pixels/flags filled as the FIFO is loaded.
module tb_fifo_line_reader;

  localparam int DW = 16;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int G  = 2;

  logic          sys_clk     = 1'b0;
  logic          sys_rst     = 1'b1;
  logic          frame_start = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty   = 1'b1;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_sof, m_eol, m_eof;
  logic          busy;

  always #5 sys_clk = ~sys_clk;

  fifo_line_reader #(
    .DATA_WIDTH (DW),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .LINE_GAP   (G)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .frame_start  (frame_start),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sof        (m_sof),
    .m_eol        (m_eol),
    .m_eof        (m_eof),
    .busy         (busy)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW+2:0] exp_q[$];  // {sof, eol, eof, data}

  int n_tests  = 0;
  int n_fail   = 0;
  int px       = 0;
  int py       = 0;
  int rd_count = 0;

  logic          o_valid, o_sof, o_eol, o_eof, o_busy, o_rd;
  logic [DW-1:0] o_data;
  logic [15:0]   v_log, b_log;
  bit            log_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load the FIFO model and record the framing the pixel must carry.
  task automatic push_px(input logic [DW-1:0] d);
    logic s, e, f;
    s = (px == 0) && (py == 0);
    e = (px == H - 1);
    f = e && (py == V - 1);
    fifo_q.push_back(d);
    exp_q.push_back({s, e, f, d});
    if (px == H - 1) begin
      px = 0;
      py = (py == V - 1) ? 0 : py + 1;
    end else begin
      px++;
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
  endtask

  // One clock: observe at negedge, pop the FIFO model just after posedge.
  task automatic cycle();
    logic [DW+2:0] e;
    refresh_fifo();
    @(negedge sys_clk);
    o_valid = m_valid;
    o_data  = m_data;
    o_sof   = m_sof;
    o_eol   = m_eol;
    o_eof   = m_eof;
    o_busy  = busy;
    o_rd    = fifo_rd_en;
    if (o_rd) rd_count++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {13'b0, m_sof, m_eol, m_eof, m_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pixel", {13'b0, m_sof, m_eol, m_eof, m_data}, {13'b0, e});
      end
    end
    if (log_en) begin
      v_log = {v_log[14:0], m_valid};
      b_log = {b_log[14:0], busy};
    end
    @(posedge sys_clk);
    #1;
    if (o_rd) begin
      if (fifo_q.size() == 0) check("pop_when_empty", {31'b0, o_rd}, 32'd0);
      else void'(fifo_q.pop_front());
    end
    refresh_fifo();
  endtask

  task automatic run_until_idle(input int max, input string tag);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (o_busy && k < max);
    check(tag, {31'b0, o_busy}, 32'd0);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] keep[$];
    int k;

    // 1: reset with a loaded FIFO
    for (int i = 1; i <= 8; i++) push_px(DW'(i));
    repeat (2) begin
      cycle();
      check("rst_outputs", {26'b0, o_valid, o_sof, o_eol, o_eof, o_busy, o_rd}, 32'd0);
      check("rst_data", {16'b0, o_data}, 32'd0);
    end
    sys_rst = 1'b0;

    // 2: full frame, 2-cycle line gap, 1-cycle pop latency
    rd_count = 0;
    v_log    = '0;
    b_log    = '0;
    log_en   = 1'b1;
    pulse_start();
    repeat (12) cycle();
    log_en = 1'b0;
    check("t2_valid_pattern", {16'b0, v_log}, 32'b0_0111_1001_1110);
    check("t2_busy_pattern", {16'b0, b_log}, 32'b0_1111_1111_1110);
    check("t2_pops", rd_count, 8);
    check("t2_sb_drained", exp_q.size(), 0);

    // 3: backpressure on pixel 2, plus frame_start while busy
    for (int i = 1; i <= 8; i++) push_px(DW'(i));
    rd_count = 0;
    pulse_start();
    k = 0;
    do begin
      cycle();
      k++;
    end while (!(o_valid && o_data == 1) && k < 20);
    check("t3_saw_px1", {16'b0, o_data}, 32'd1);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_start = (i == 0);
      cycle();
      check("t3_hold_flags", {27'b0, o_valid, o_sof, o_eol, o_eof, o_rd}, 32'b10000);
      check("t3_hold_data", {16'b0, o_data}, 32'd2);
    end
    frame_start = 1'b0;
    m_ready     = 1'b1;
    run_until_idle(40, "t3_done");
    check("t3_pops", rd_count, 8);
    check("t3_sb_drained", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t3_start_not_queued", {30'b0, o_busy, o_rd}, 32'd0);
    end

    // 5b/4: start with empty FIFO, then underflow mid-line
    rd_count = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_empty_wait", {29'b0, o_busy, o_valid, o_rd}, 32'b100);
    end
    for (int i = 1; i <= 3; i++) push_px(DW'(i));
    k = 0;
    do begin
      cycle();
      k++;
    end while (!(o_valid && o_data == 3) && k < 20);
    check("t4_saw_px3", {16'b0, o_data}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_underflow_idle", {30'b0, o_busy, o_valid}, 32'b10);
    end
    for (int i = 4; i <= 8; i++) push_px(DW'(i));
    run_until_idle(40, "t4_done");
    check("t4_pops", rd_count, 8);
    check("t4_sb_drained", exp_q.size(), 0);

    // 6: reset after two pixels accepted
    for (int i = 1; i <= 8; i++) push_px(DW'(i));
    pulse_start();
    k = 0;
    do begin
      cycle();
      k++;
    end while (!(o_valid && o_data == 2) && k < 20);
    check("t6_saw_px2", {16'b0, o_data}, 32'd2);
    sys_rst = 1'b1;
    cycle();
    check("t6_no_pop_in_rst", {31'b0, o_rd}, 32'd0);
    sys_rst = 1'b0;
    cycle();
    check("t6_after_rst", {30'b0, o_valid, o_busy}, 32'd0);
    check("t6_fifo_left", fifo_q.size(), 5);
    // Restart framing from whatever the FIFO still holds.
    keep = fifo_q;
    fifo_q.delete();
    exp_q.delete();
    px = 0;
    py = 0;
    foreach (keep[i]) push_px(keep[i]);
    for (int i = 9; i <= 11; i++) push_px(DW'(i));
    pulse_start();
    run_until_idle(40, "t6_done");
    check("t6_sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
